// File: rtl/packed_write_queue.sv
// Multi-lane write queue: packs up to numParallelIn lanes per cycle into a
// circular FIFO, optionally compressing 8-bit elements into 4-bit nibbles.
module packed_write_queue #(
    parameter int numParallelIn       = 4,
    parameter int elementsPerLane     = 32,
    parameter int maxBits             = 8,
    parameter int writeInterfaceWidth = 256,
    parameter int writeAddrWidth      = 32,
    parameter int queueDepth          = 8
) (
    input  logic                                         clk,
    input  logic                                         nrst,
    input  logic                                         clear_i,
    input  logic                                         cfg_pack4_i,
    input  logic [numParallelIn*writeInterfaceWidth-1:0] data_in,
    input  logic [numParallelIn*writeAddrWidth-1:0]      addr_in,
    input  logic [numParallelIn-1:0]                     valid_in,
    output logic                                         ready_out,
    output logic [writeInterfaceWidth-1:0]               data_out,
    output logic [writeAddrWidth-1:0]                    addr_out,
    output logic                                         valid_out,
    input  logic                                         ready_in,
    output logic [$clog2(queueDepth):0]                  count_o,
    output logic                                         overflow_o
);

    localparam int PW = $clog2(queueDepth);
    localparam int CW = PW + 1;
    localparam int W  = writeInterfaceWidth;
    localparam int AW = writeAddrWidth;

    logic [W-1:0]  r_data [queueDepth];
    logic [AW-1:0] r_addr [queueDepth];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;

    logic [PW-1:0] w_off  [numParallelIn];
    logic [W-1:0]  w_pack [numParallelIn];
    logic [CW-1:0] w_npush;
    logic [CW-1:0] w_free;
    logic          w_push_req;
    logic          w_push;
    logic          w_pop;

    // Each active lane takes the slot after all lower-indexed active lanes.
    always_comb begin
        w_npush = '0;
        for (int i = 0; i < numParallelIn; i++) begin
            w_off[i] = w_npush[PW-1:0];
            if (valid_in[i]) w_npush = w_npush + CW'(1);
        end
    end

    always_comb begin
        for (int i = 0; i < numParallelIn; i++) begin
            w_pack[i] = '0;
            if (cfg_pack4_i) begin
                for (int k = 0; k < elementsPerLane; k++)
                    w_pack[i][k*4 +: 4] = data_in[i*W + k*maxBits +: 4];
            end else begin
                w_pack[i] = data_in[i*W +: W];
            end
        end
    end

    assign w_free     = CW'(queueDepth) - r_count;
    assign ready_out  = w_free >= CW'(numParallelIn);
    assign valid_out  = r_count != '0;
    assign w_push_req = |valid_in;
    assign w_push     = w_push_req && ready_out && !clear_i;
    assign w_pop      = valid_out && ready_in && !clear_i;

    assign data_out   = valid_out ? r_data[r_rptr] : '0;
    assign addr_out   = valid_out ? r_addr[r_rptr] : '0;
    assign count_o    = r_count;
    assign overflow_o = r_ovf;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (clear_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + w_npush[PW-1:0];
            if (w_pop) r_rptr <= r_rptr + PW'(1);
            r_count <= r_count + (w_push ? w_npush : '0) - CW'(w_pop);
            if (w_push_req && !ready_out) r_ovf <= 1'b1;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        for (int i = 0; i < numParallelIn; i++) begin
            if (w_push && valid_in[i]) begin
                r_data[r_wptr + w_off[i]] <= w_pack[i];
                r_addr[r_wptr + w_off[i]] <= addr_in[i*AW +: AW];
            end
        end
    end

endmodule

// File: tb/tb_packed_write_queue.sv
// Directed bench for packed_write_queue: vector table plus
// hand sequences for pack4, pointer wrap, async reset and clear.
module tb_packed_write_queue;

    logic          clk = 1'b0;
    logic          nrst;
    logic          clear_i;
    logic          cfg_pack4_i;
    logic [1023:0] data_in;
    logic [127:0]  addr_in;
    logic [3:0]    valid_in;
    logic          ready_out;
    logic [255:0]  data_out;
    logic [31:0]   addr_out;
    logic          valid_out;
    logic          ready_in;
    logic [3:0]    count_o;
    logic          overflow_o;

    int n_chk  = 0;
    int n_fail = 0;

    packed_write_queue dut (
        .clk        (clk),
        .nrst       (nrst),
        .clear_i    (clear_i),
        .cfg_pack4_i(cfg_pack4_i),
        .data_in    (data_in),
        .addr_in    (addr_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .data_out   (data_out),
        .addr_out   (addr_out),
        .valid_out  (valid_out),
        .ready_in   (ready_in),
        .count_o    (count_o),
        .overflow_o (overflow_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        clr;
        logic        p4;
        logic [3:0]  v;
        logic        rdy;
        logic [31:0] abase;
        logic [3:0]  e_cnt;
        logic        e_vo;
        logic        e_ro;
        logic [31:0] e_ao;
        logic        e_ov;
    } vec_t;

    vec_t tbl [14];

    function automatic logic [255:0] lanedata(input logic [31:0] a);
        logic [255:0] d;
        for (int k = 0; k < 32; k++) d[k*8 +: 8] = a[10:3] + 8'(k);
        return d;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic clr, input logic p4, input logic [3:0] v,
                        input logic rdy, input logic [31:0] abase);
        clear_i     = clr;
        cfg_pack4_i = p4;
        valid_in    = v;
        ready_in    = rdy;
        for (int i = 0; i < 4; i++) begin
            addr_in[i*32 +: 32]   = abase + 32'(i * 32'h20);
            data_in[i*256 +: 256] = lanedata(abase + 32'(i * 32'h20));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string nm, input logic [3:0] cnt,
                            input logic [31:0] ao);
        chk({nm, "_cnt"}, 256'(count_o), 256'(cnt));
        chk({nm, "_addr"}, 256'(addr_out), 256'(ao));
        chk({nm, "_data"}, data_out, cnt != 0 ? lanedata(ao) : 256'd0);
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 4'hF, 1'b0, 32'h000, 4'd4, 1'b1, 1'b1, 32'h000, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 4'h0, 1'b1, 32'h000, 4'd3, 1'b1, 1'b1, 32'h020, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 4'h0, 1'b1, 32'h000, 4'd2, 1'b1, 1'b1, 32'h040, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 4'h0, 1'b1, 32'h000, 4'd1, 1'b1, 1'b1, 32'h060, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 4'h0, 1'b1, 32'h000, 4'd0, 1'b0, 1'b1, 32'h000, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 4'hA, 1'b0, 32'h100, 4'd2, 1'b1, 1'b1, 32'h120, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 4'h0, 1'b1, 32'h000, 4'd1, 1'b1, 1'b1, 32'h160, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 4'h0, 1'b1, 32'h000, 4'd0, 1'b0, 1'b1, 32'h000, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 4'hF, 1'b0, 32'h200, 4'd4, 1'b1, 1'b1, 32'h200, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 4'h1, 1'b0, 32'h300, 4'd5, 1'b1, 1'b0, 32'h200, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 4'h1, 1'b0, 32'h400, 4'd5, 1'b1, 1'b0, 32'h200, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 4'h0, 1'b0, 32'h000, 4'd5, 1'b1, 1'b0, 32'h200, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 4'hF, 1'b1, 32'h500, 4'd4, 1'b1, 1'b1, 32'h220, 1'b1};
        tbl[13] = '{1'b1, 1'b0, 4'h0, 1'b0, 32'h000, 4'd0, 1'b0, 1'b1, 32'h000, 1'b0};

        nrst        = 1'b0;
        clear_i     = 1'b0;
        cfg_pack4_i = 1'b0;
        valid_in    = '0;
        ready_in    = 1'b0;
        data_in     = '0;
        addr_in     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cnt", 256'(count_o), 256'd0);
        chk("rst_vo", 256'(valid_out), 256'd0);
        chk("rst_data", data_out, 256'd0);
        chk("rst_addr", 256'(addr_out), 256'd0);
        chk("rst_ovf", 256'(overflow_o), 256'd0);
        @(negedge clk);
        nrst = 1'b1;
        #1;
        chk("rst_ro", 256'(ready_out), 256'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].clr, tbl[i].p4, tbl[i].v, tbl[i].rdy, tbl[i].abase);
            chk_head($sformatf("vec%0d", i), tbl[i].e_cnt, tbl[i].e_ao);
            chk($sformatf("vec%0d_vo", i), 256'(valid_out), 256'(tbl[i].e_vo));
            chk($sformatf("vec%0d_ro", i), 256'(ready_out), 256'(tbl[i].e_ro));
            chk($sformatf("vec%0d_ovf", i), 256'(overflow_o), 256'(tbl[i].e_ov));
        end

        // 4-bit packing, then mode change must not touch the stored entry
        clear_i     = 1'b0;
        cfg_pack4_i = 1'b1;
        valid_in    = 4'b0001;
        ready_in    = 1'b0;
        data_in     = '0;
        data_in[255:0] = {32{8'h3A}};
        addr_in     = '0;
        addr_in[31:0] = 32'hA00;
        @(posedge clk);
        #1;
        chk("p4_lo", 256'(data_out[127:0]), 256'({32{4'hA}}));
        chk("p4_hi", 256'(data_out[255:128]), 256'd0);
        chk("p4_cnt", 256'(count_o), 256'd1);
        cfg_pack4_i = 1'b0;
        valid_in    = '0;
        @(posedge clk);
        #1;
        chk("p4_keep", data_out, {128'd0, {32{4'hA}}});

        // Wrap: drive wptr to 6, then push four while popping one
        step(1'b1, 1'b0, 4'h0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 4'hF, 1'b0, 32'h500);
        repeat (4) step(1'b0, 1'b0, 4'h0, 1'b1, 32'h0);
        chk("wr_empty", 256'(count_o), 256'd0);
        step(1'b0, 1'b0, 4'h3, 1'b0, 32'h700);
        chk_head("wr_pre", 4'd2, 32'h700);
        step(1'b0, 1'b0, 4'hF, 1'b1, 32'h600);
        chk_head("wr_push", 4'd5, 32'h720);
        chk("wr_ro", 256'(ready_out), 256'd0);
        step(1'b0, 1'b0, 4'h0, 1'b1, 32'h0);
        chk_head("wr_s6", 4'd4, 32'h600);
        step(1'b0, 1'b0, 4'h0, 1'b1, 32'h0);
        chk_head("wr_s7", 4'd3, 32'h620);
        step(1'b0, 1'b0, 4'h0, 1'b1, 32'h0);
        chk_head("wr_s0", 4'd2, 32'h640);
        step(1'b0, 1'b0, 4'h0, 1'b1, 32'h0);
        chk_head("wr_s1", 4'd1, 32'h660);
        step(1'b0, 1'b0, 4'h0, 1'b1, 32'h0);
        chk_head("wr_end", 4'd0, 32'h0);

        // Asynchronous reset mid-cycle
        step(1'b0, 1'b0, 4'h7, 1'b0, 32'h800);
        chk_head("ar_pre", 4'd3, 32'h800);
        valid_in = '0;
        #2;
        nrst = 1'b0;
        #1;
        chk("ar_vo", 256'(valid_out), 256'd0);
        chk("ar_cnt", 256'(count_o), 256'd0);
        chk("ar_data", data_out, 256'd0);
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;

        // Clear overrides a simultaneous push and pop
        step(1'b0, 1'b0, 4'h1, 1'b0, 32'h900);
        chk_head("cl_pre", 4'd1, 32'h900);
        step(1'b1, 1'b0, 4'hF, 1'b1, 32'hA00);
        chk("cl_cnt", 256'(count_o), 256'd0);
        chk("cl_vo", 256'(valid_out), 256'd0);
        step(1'b0, 1'b0, 4'h0, 1'b0, 32'h0);
        chk("cl_hold", 256'(count_o), 256'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
